// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: PC+4 fetch sequencer that hides the 1-cycle ROM latency
// behind a show-ahead {pc,inst} FIFO with valid/ready output and redirect flush.
module inst_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       rom_ce_o,
  output logic [ADDR_W-1:0]          rom_addr_o,
  input  logic [DATA_W-1:0]          rom_data_i,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  input  logic                       if_ready_i,
  output logic                       if_valid_o,
  output logic [ADDR_W-1:0]          if_pc_o,
  output logic [DATA_W-1:0]          if_inst_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {BOOT, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [DATA_W-1:0] inst_mem_q [DEPTH];
  logic issue, push, pop;
  // Credit counts the outstanding ROM read so a response always finds a free slot.
  always_comb begin
    issue = state_q == RUN && !redirect_i && (count_q + CW'(inflight_q) < CW'(DEPTH));
    push = inflight_q && !redirect_i;
    if_valid_o = count_q != '0 && !redirect_i;
    pop = if_valid_o && if_ready_i;
    rom_ce_o = issue;
    rom_addr_o = fetch_pc_q;
    if_pc_o = if_valid_o ? pc_mem_q[rd_ptr_q] : '0;
    if_inst_o = if_valid_o ? inst_mem_q[rd_ptr_q] : '0;
    count_o = count_q;
    state_d = RUN;
    fetch_pc_d = redirect_i ? redirect_pc_i : issue ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
    inflight_d = issue;
    req_pc_d = issue ? fetch_pc_q : req_pc_q;
    wr_ptr_d = redirect_i ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = redirect_i ? '0 : rd_ptr_q + PW'(pop);
    count_d = redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      fetch_pc_q <= RESET_PC;
      req_pc_q <= '0;
      inflight_q <= 1'b0;
      count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q <= req_pc_d;
      inflight_q <= inflight_d;
      count_q <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q] <= req_pc_q;
      inst_mem_q[wr_ptr_q] <= rom_data_i;
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) !(push && count_q == CW'(DEPTH)));
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: directed checks of fetch sequencing, backpressure,
// redirect flush, PC wrap and mid-stream reset against a data=address ROM.
module tb_inst_prefetch_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rom_ce_o;
  logic [31:0] rom_addr_o, rom_data_i, redirect_pc_i, if_pc_o, if_inst_o;
  logic redirect_i = 1'b0, if_ready_i = 1'b0, if_valid_o;
  logic [2:0] count_o;
  int checks = 0, errors = 0;
  int n;
  logic [31:0] exp_pc;
  inst_prefetch_queue dut (
    .clk(clk), .rst_n(rst_n), .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .if_ready_i(if_ready_i), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o),
    .if_inst_o(if_inst_o), .count_o(count_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rom_data_i <= rom_addr_o;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 64'(if_valid_o), 64'd1);
    chk({tag, "_pc"}, 64'(if_pc_o), 64'(pc));
    chk({tag, "_inst"}, 64'(if_inst_o), 64'(pc));
  endtask
  task automatic rst_seq(input logic rdy);
    cyc();
    rst_n = 1'b0;
    redirect_i = 1'b0;
    if_ready_i = rdy;
    #1;
    chk("rst_ce", 64'(rom_ce_o), 64'd0);
    chk("rst_addr", 64'(rom_addr_o), 64'd0);
    chk("rst_valid", 64'(if_valid_o), 64'd0);
    chk("rst_pc", 64'(if_pc_o), 64'd0);
    chk("rst_inst", 64'(if_inst_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    cyc();
    rst_n = 1'b1;
  endtask
  initial begin
    redirect_pc_i = '0;
    // reset release with ready high: 2-cycle latency then gapless stream
    rst_seq(1'b1);
    cyc();
    chk("s1_ce", 64'(rom_ce_o), 64'd1);
    chk("s1_addr", 64'(rom_addr_o), 64'h0);
    chk("s1_valid0", 64'(if_valid_o), 64'd0);
    cyc();
    chk("s1_addr1", 64'(rom_addr_o), 64'h4);
    chk("s1_valid1", 64'(if_valid_o), 64'd0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      head("s1_stream", 32'(i * 4));
    end
    // backpressure from reset: queue fills, issue stops, head holds
    rst_seq(1'b0);
    for (int i = 0; i < 8; i++) cyc();
    chk("s2_count", 64'(count_o), 64'd4);
    chk("s2_ce", 64'(rom_ce_o), 64'd0);
    chk("s2_addr", 64'(rom_addr_o), 64'h10);
    head("s2_hold", 32'h0);
    cyc();
    head("s2_hold2", 32'h0);
    if_ready_i = 1'b1;
    #1;
    exp_pc = 32'h0;
    n = 0;
    for (int i = 0; i < 24 && n < 8; i++) begin
      if (if_valid_o) begin
        chk("s2_pc", 64'(if_pc_o), 64'(exp_pc));
        chk("s2_inst", 64'(if_inst_o), 64'(exp_pc));
        exp_pc += 4;
        n++;
      end
      cyc();
    end
    chk("s2_accepted", 64'(n), 64'd8);
    // redirect in the cycle the 0x8 response returns
    rst_seq(1'b1);
    cyc();
    cyc();
    cyc();
    head("s3_first", 32'h0);
    cyc();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    #1;
    chk("s3_rd_valid", 64'(if_valid_o), 64'd0);
    chk("s3_rd_ce", 64'(rom_ce_o), 64'd0);
    cyc();
    redirect_i = 1'b0;
    #1;
    chk("s3_count", 64'(count_o), 64'd0);
    chk("s3_valid", 64'(if_valid_o), 64'd0);
    chk("s3_ce", 64'(rom_ce_o), 64'd1);
    chk("s3_addr", 64'(rom_addr_o), 64'h100);
    cyc();
    chk("s3_gap", 64'(if_valid_o), 64'd0);
    cyc();
    head("s3_new", 32'h100);
    cyc();
    head("s3_next", 32'h104);
    // redirect to the top of the address space, PC wraps to 0
    cyc();
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    #1;
    chk("s5_rd_valid", 64'(if_valid_o), 64'd0);
    cyc();
    redirect_i = 1'b0;
    #1;
    chk("s5_addr0", 64'(rom_addr_o), 64'hFFFF_FFFC);
    cyc();
    chk("s5_addr1", 64'(rom_addr_o), 64'h0);
    chk("s5_ce1", 64'(rom_ce_o), 64'd1);
    cyc();
    head("s5_top", 32'hFFFF_FFFC);
    cyc();
    head("s5_wrap", 32'h0);
    cyc();
    head("s5_wrap1", 32'h4);
    // mid-stream reset, then restart at 0
    rst_seq(1'b1);
    cyc();
    chk("s6_ce", 64'(rom_ce_o), 64'd1);
    chk("s6_addr", 64'(rom_addr_o), 64'h0);
    cyc();
    cyc();
    head("s6_restart", 32'h0);
    cyc();
    head("s6_restart1", 32'h4);
    // redirect with two entries queued and ready high: no pop, queue emptied
    rst_seq(1'b0);
    cyc();
    cyc();
    cyc();
    cyc();
    chk("s4_count2", 64'(count_o), 64'd2);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    if_ready_i = 1'b1;
    #1;
    chk("s4_rd_valid", 64'(if_valid_o), 64'd0);
    chk("s4_rd_pc", 64'(if_pc_o), 64'd0);
    cyc();
    redirect_i = 1'b0;
    #1;
    chk("s4_count", 64'(count_o), 64'd0);
    chk("s4_valid", 64'(if_valid_o), 64'd0);
    chk("s4_addr", 64'(rom_addr_o), 64'h200);
    cyc();
    cyc();
    head("s4_new", 32'h200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
